// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI master arbiter.
package spi_arb_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int NUM_REQ    = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        WAIT,
        HOLD
    } spi_arb_state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter: SCK divider, one shared tx/rx shift register and
// a half-period counter, started by a one-cycle start pulse.
module spi_byte_engine
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  skip_setup,
    input  logic [SPI_BYTE_W-1:0] tx_byte,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  setup_done,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rx_byte
);

    localparam int             DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            half_cnt;
    logic [SPI_BYTE_W-1:0] shreg;
    logic                  active;
    logic                  in_setup;
    logic                  tick;

    assign tick       = active && (div_cnt == '0);
    assign setup_done = tick && in_setup;
    assign done       = tick && !in_setup && (half_cnt == 4'd15);
    assign rx_byte    = shreg;

    // half_cnt holds the number of SCK toggles already made in this byte;
    // the 16th toggle is the final falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            active   <= 1'b0;
            in_setup <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (start) begin
            shreg    <= tx_byte;
            mosi     <= tx_byte[SPI_BYTE_W-1];
            div_cnt  <= DIV_MAX;
            half_cnt <= '0;
            active   <= 1'b1;
            in_setup <= !skip_setup;
            sclk     <= 1'b0;
        end else if (active) begin
            if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end else begin
                div_cnt <= DIV_MAX;
                if (in_setup) begin
                    in_setup <= 1'b0;
                    sclk     <= 1'b1;
                    shreg    <= {shreg[SPI_BYTE_W-2:0], miso};
                    half_cnt <= 4'd1;
                end else if (half_cnt == 4'd15) begin
                    // last falling edge: MOSI is left on the final bit
                    sclk   <= 1'b0;
                    active <= 1'b0;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                    sclk     <= ~sclk;
                    if (!sclk) begin
                        shreg <= {shreg[SPI_BYTE_W-2:0], miso};
                    end else begin
                        mosi <= shreg[SPI_BYTE_W-1];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master between two byte-stream requesters;
// SS is held low for a whole multi-byte transaction of the granted requester.
//
// state | meaning
// IDLE  | SS high, waiting for any request; grant by round-robin
// SETUP | SS low, MOSI=bit7, SCK low for one half-period
// SHIFT | engine clocks out/in the 8 bits
// DONE  | one-cycle response pulse to the owner
// WAIT  | SS low, SCK low, waiting for the owner's next byte
// HOLD  | SS low for one half-period after the last byte
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                             io_mainClk,
    input  logic                             io_reset,
    input  logic [NUM_REQ-1:0]               io_req_valid,
    output logic [NUM_REQ-1:0]               io_req_ready,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0]    io_req_data,
    input  logic [NUM_REQ-1:0]               io_req_last,
    output logic [NUM_REQ-1:0]               io_rsp_valid,
    output logic [SPI_BYTE_W-1:0]            io_rsp_data,
    output logic                             io_busy,
    output logic                             io_owner,
    output logic                             io_spi_sclk,
    output logic                             io_spi_mosi,
    input  logic                             io_spi_miso,
    output logic                             io_spi_ss
);

    localparam int               DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    spi_arb_state_t        state;
    logic                  last_q;
    logic [DIV_W-1:0]      hold_cnt;
    logic                  grant_idx;
    logic                  accept_idx;
    logic                  accept;
    logic [SPI_BYTE_W-1:0] tx_byte;
    logic                  eng_setup_done;
    logic                  eng_done;
    logic [SPI_BYTE_W-1:0] eng_rx;

    // With both requesting, the one that did not have the last grant wins.
    always_comb begin
        grant_idx = ~io_owner;
        if (io_req_valid == 2'b01) begin
            grant_idx = 1'b0;
        end else if (io_req_valid == 2'b10) begin
            grant_idx = 1'b1;
        end
    end

    always_comb begin
        io_req_ready = '0;
        case (state)
            IDLE:    if (|io_req_valid) io_req_ready = req_onehot(grant_idx);
            WAIT:    io_req_ready = req_onehot(io_owner);
            default: io_req_ready = '0;
        endcase
    end

    assign accept     = |(io_req_valid & io_req_ready);
    assign accept_idx = (state == WAIT) ? io_owner : grant_idx;
    assign tx_byte    = accept_idx ? io_req_data[2*SPI_BYTE_W-1:SPI_BYTE_W]
                                   : io_req_data[SPI_BYTE_W-1:0];
    assign io_busy    = (state != IDLE);

    spi_byte_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clk        (io_mainClk),
        .rst        (io_reset),
        .start      (accept),
        .skip_setup (state == WAIT),
        .tx_byte    (tx_byte),
        .miso       (io_spi_miso),
        .sclk       (io_spi_sclk),
        .mosi       (io_spi_mosi),
        .setup_done (eng_setup_done),
        .done       (eng_done),
        .rx_byte    (eng_rx)
    );

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state        <= IDLE;
            last_q       <= 1'b0;
            hold_cnt     <= '0;
            io_owner     <= 1'b0;
            io_spi_ss    <= 1'b1;
            io_rsp_valid <= '0;
            io_rsp_data  <= '0;
        end else begin
            io_rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        io_owner  <= grant_idx;
                        last_q    <= io_req_last[grant_idx];
                        io_spi_ss <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (eng_setup_done) state <= SHIFT;
                end
                SHIFT: begin
                    if (eng_done) begin
                        io_rsp_valid <= req_onehot(io_owner);
                        io_rsp_data  <= eng_rx;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    hold_cnt <= DIV_MAX;
                    state    <= last_q ? HOLD : WAIT;
                end
                WAIT: begin
                    if (accept) begin
                        last_q <= io_req_last[io_owner];
                        state  <= SHIFT;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        io_spi_ss <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: slave model, response scoreboard, vector
// table of single-byte transactions plus multi-cycle corner sequences.
module tb_spi_master_arbiter;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // CLK_DIV=4 instance
    logic        rst;
    logic        req_v [2];
    logic [7:0]  req_d [2];
    logic        req_l [2];
    logic [1:0]  ready, rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy, owner, sclk, mosi, miso, ss;

    spi_master_arbiter #(.CLK_DIV(D)) dut (
        .io_mainClk   (clk),
        .io_reset     (rst),
        .io_req_valid ({req_v[1], req_v[0]}),
        .io_req_ready (ready),
        .io_req_data  ({req_d[1], req_d[0]}),
        .io_req_last  ({req_l[1], req_l[0]}),
        .io_rsp_valid (rsp_valid),
        .io_rsp_data  (rsp_data),
        .io_busy      (busy),
        .io_owner     (owner),
        .io_spi_sclk  (sclk),
        .io_spi_mosi  (mosi),
        .io_spi_miso  (miso),
        .io_spi_ss    (ss)
    );

    // CLK_DIV=2 instance
    logic        rst2;
    logic [1:0]  v2, l2, ready2, rsp_v2;
    logic [15:0] d2;
    logic [7:0]  rsp_d2;
    logic        busy2, owner2, sclk2, mosi2, ss2;
    logic        miso2 = 1'b1;

    spi_master_arbiter #(.CLK_DIV(2)) dut2 (
        .io_mainClk   (clk),
        .io_reset     (rst2),
        .io_req_valid (v2),
        .io_req_ready (ready2),
        .io_req_data  (d2),
        .io_req_last  (l2),
        .io_rsp_valid (rsp_v2),
        .io_rsp_data  (rsp_d2),
        .io_busy      (busy2),
        .io_owner     (owner2),
        .io_spi_sclk  (sclk2),
        .io_spi_mosi  (mosi2),
        .io_spi_miso  (miso2),
        .io_spi_ss    (ss2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } rsp_exp_t;

    rsp_exp_t   sb_q[$];
    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];
    int         grant_log[$];

    int rsp_count   = 0;
    int ss_rise_cyc = -1;
    int ss_falls    = 0;
    int rise_count  = 0;

    // Slave model + response scoreboard, all sampled mid-cycle
    logic       prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [7:0] slv_cur = 8'h00, slv_cap = 8'h00;
    int         slv_bit = 0;
    bit         slv_loaded = 1'b0;
    rsp_exp_t   e;

    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            rsp_count++;
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_owner", rsp_valid, 1 << e.idx);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
        if (ss && !prev_ss) ss_rise_cyc = cyc;
        if (!ss && prev_ss) ss_falls++;
        if (ss) begin
            slv_bit    = 0;
            slv_loaded = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                rise_count++;
                slv_cap = {slv_cap[6:0], mosi};
                slv_bit++;
                if (slv_bit == 8) begin
                    if (mosi_q.size() == 0) chk("mosi_unexpected", mosi_q.size(), 1);
                    else chk("mosi_byte", slv_cap, mosi_q.pop_front());
                    slv_bit    = 0;
                    slv_loaded = 1'b0;
                end
            end
            if (!slv_loaded && miso_q.size() > 0) begin
                slv_cur    = miso_q.pop_front();
                slv_loaded = 1'b1;
            end
        end
        miso      = slv_loaded ? slv_cur[7 - slv_bit] : 1'b0;
        prev_ss   = ss;
        prev_sclk = sclk;
    end

    // CLK_DIV=2 monitor
    int         hi_run = 0, pulses2 = 0, rsp2_cyc = -1;
    logic [7:0] rsp2_data = 8'h00;
    logic [1:0] rsp2_v = 2'b00;
    logic       prev_sclk2 = 1'b0;

    always @(negedge clk) begin
        if (sclk2) begin
            hi_run++;
        end else if (prev_sclk2) begin
            pulses2++;
            chk("d2_sclk_high_width", hi_run, 2);
            hi_run = 0;
        end
        if (rsp_v2 != 2'b00) begin
            rsp2_cyc  = cyc;
            rsp2_data = rsp_d2;
            rsp2_v    = rsp_v2;
        end
        prev_sclk2 = sclk2;
    end

    task automatic send(input int idx, input logic [7:0] d, input logic l,
                        input logic [7:0] sb, output int acc);
        int n = 0;
        rsp_exp_t x;
        req_d[idx] = d;
        req_l[idx] = l;
        req_v[idx] = 1'b1;
        #1;
        while (!ready[idx] && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = cyc;
        if (!ready[idx]) begin
            chk("accept_timeout", ready[idx], 1);
            acc = -1;
        end else begin
            grant_log.push_back(idx);
            mosi_q.push_back(d);
            miso_q.push_back(sb);
            x.idx  = idx;
            x.data = sb;
            x.cyc  = cyc + 1 + 16 * D;
            sb_q.push_back(x);
        end
        @(negedge clk);
        req_v[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !ss) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] rx;
        int         exp_owner;
    } vec_t;

    vec_t vecs [5];
    int   exp_g [4];
    int   a0, a1, f0, r0, k, n;

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;
            req_d[i] = 8'h00;
            req_l[i] = 1'b0;
        end
        v2 = 2'b00;
        d2 = 16'h0000;
        l2 = 2'b00;
        repeat (3) @(negedge clk);

        chk("rst_ss", ss, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("d2_rst_ss", ss2, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte transactions; first row is A5 out / 3C in
        vecs[0] = '{0, 8'hA5, 8'h3C, 0};
        vecs[1] = '{1, 8'h5A, 8'hC3, 1};
        vecs[2] = '{0, 8'h00, 8'hFF, 0};
        vecs[3] = '{1, 8'hFF, 8'h00, 1};
        vecs[4] = '{0, 8'h81, 8'h7E, 0};
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].idx, vecs[i].tx, 1'b1, vecs[i].rx, a0);
            chk("vec_owner", owner, vecs[i].exp_owner);
            wait_idle();
            chk("vec_ss_release_cycle", ss_rise_cyc, a0 + 2 + 17 * D);
        end

        // Multi-byte from requester 1, SS held across all bytes
        f0 = ss_falls;
        r0 = rsp_count;
        send(1, 8'h01, 1'b0, 8'h11, a1);
        send(1, 8'h02, 1'b0, 8'h22, a1);
        send(1, 8'h03, 1'b1, 8'h33, a1);
        wait_idle();
        chk("multi_ss_falls", ss_falls - f0, 1);
        chk("multi_rsp_count", rsp_count - r0, 3);

        // Simultaneous requests after reset: 1,0,1,0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        grant_log.delete();
        f0 = ss_falls;
        fork
            begin
                send(0, 8'h3A, 1'b1, 8'hA3, a0);
                send(0, 8'h4B, 1'b1, 8'hB4, a0);
            end
            begin
                send(1, 8'h5C, 1'b1, 8'hC5, a1);
                send(1, 8'h6D, 1'b1, 8'hD6, a1);
            end
        join
        wait_idle();
        exp_g = '{1, 0, 1, 0};
        chk("sim_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("sim_grant_order", grant_log[i], exp_g[i]);
        end
        chk("sim_ss_falls", ss_falls - f0, 4);

        // Requester 1 stalled while requester 0 sits in WAIT
        fork
            begin
                send(0, 8'hC0, 1'b0, 8'h0C, a0);
                repeat (90) @(negedge clk);
                send(0, 8'hDE, 1'b1, 8'hED, a0);
            end
            begin
                repeat (2) @(negedge clk);
                send(1, 8'h77, 1'b1, 8'h88, a1);
            end
        join
        chk("stall_release_cycle", ss_rise_cyc, a0 + 2 + 17 * D);
        chk("stall_grant_cycle", a1, ss_rise_cyc);
        wait_idle();

        // Reset after the third rising edge
        send(1, 8'h96, 1'b1, 8'h69, a1);
        r0 = rise_count;
        n = 0;
        while (rise_count < r0 + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_third_rise_seen", rise_count - r0, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ss", ss, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        sb_q.delete();
        mosi_q.delete();
        miso_q.delete();
        rst = 1'b0;
        r0 = rsp_count;
        repeat (80) @(negedge clk);
        chk("mid_no_rsp", rsp_count - r0, 0);

        // Minimum divider: 0xFF, MISO tied high
        rst2 = 1'b0;
        @(negedge clk);
        v2 = 2'b01;
        d2 = 16'h00FF;
        l2 = 2'b01;
        #1;
        chk("d2_ready", ready2, 2'b01);
        k = cyc;
        @(negedge clk);
        v2 = 2'b00;
        n = 0;
        while ((busy2 || !ss2) && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("d2_rsp_cycle", rsp2_cyc, k + 33);
        chk("d2_rsp_data", rsp2_data, 8'hFF);
        chk("d2_rsp_owner", rsp2_v, 2'b01);
        chk("d2_sclk_pulses", pulses2, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
